// File: rtl/mr_lsu_pkg.sv
// Shared config and types for the mr-soc load/store stage.
// Optional feature macro: MR_LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
package mr_lsu_pkg;

    localparam int XLEN        = 32;
    localparam int REGSEL_BITS = 5;
    localparam int STRB_W      = XLEN / 8;

    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2
    } e_memops;

    typedef enum logic [1:0] {
        MEMSZ_B = 2'd0,
        MEMSZ_H = 2'd1,
        MEMSZ_W = 2'd2
    } e_memsz;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_MEM  = 1'b1
    } e_lsu_state;

    // Natural alignment of the byte offset for a given access size.
    function automatic logic [1:0] align_off(input e_memsz sz, input logic [1:0] off);
        case (sz)
            MEMSZ_B: align_off = off;
            MEMSZ_H: align_off = {off[1], 1'b0};
            default: align_off = 2'b00;
        endcase
    endfunction

    // True when the offset is not naturally aligned for the size.
    function automatic logic misaligned(input e_memsz sz, input logic [1:0] off);
        case (sz)
            MEMSZ_H: misaligned = off[0];
            MEMSZ_W: misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mr_lsu_lane.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; off is expected to be already aligned for the size.
module mr_lsu_lane
    import mr_lsu_pkg::*;
(
    input  e_memsz                size,
    input  logic [1:0]            off,
    input  logic                  sgn,
    input  logic [XLEN-1:0]       payload,
    input  logic [XLEN-1:0]       rdata,
    output logic [XLEN-1:0]       wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic [XLEN-1:0]       ld_val
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Replicate store data across lanes, select enables, and extend the loaded field.
    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        wdata  = payload;
        wstrb  = '1;
        ld_val = rdata;
        case (size)
            MEMSZ_B: begin
                wdata  = {(XLEN/8){payload[7:0]}};
                wstrb  = STRB_W'(1) << off;
                ld_val = {{(XLEN-8){sgn & byte_v[7]}}, byte_v};
            end
            MEMSZ_H: begin
                wdata  = {(XLEN/16){payload[15:0]}};
                wstrb  = STRB_W'(3) << {off[1], 1'b0};
                ld_val = {{(XLEN-16){sgn & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mr_lsu.sv
// mr-soc load/store stage: passes ALU results to writeback or performs one
// data-bus load/store per accepted request.
// Optional feature macro: MR_LSU_MISALIGN_TRAP_EN -- misaligned H/W accesses
// pulse lsu_fault instead of being silently aligned.
module mr_lsu
    import mr_lsu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [XLEN-1:0]        ex_dest,
    input  logic [REGSEL_BITS-1:0] ex_dest_reg,
    input  e_memops                ex_memop,
    input  e_memsz                 ex_size,
    input  logic                   ex_signed,
    input  logic [XLEN-1:0]        ex_payload,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [STRB_W-1:0]      mem_wstrb,
    input  logic                   mem_ack,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [REGSEL_BITS-1:0] wb_reg,
    output logic [XLEN-1:0]        wb_data,
    output logic                   lsu_fault,
    output logic [XLEN-1:0]        lsu_fault_addr
);

    e_lsu_state             state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]      mem_wstrb_q, mem_wstrb_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [REGSEL_BITS-1:0] wb_reg_q, wb_reg_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;
    e_memsz                 size_q, size_d;
    logic [1:0]             off_q, off_d;
    logic                   sgn_q, sgn_d;
    logic [REGSEL_BITS-1:0] dreg_q, dreg_d;

    logic                   accept;
    logic                   is_mem;
    logic                   trap;
    logic [1:0]             off_eff;
    e_memsz                 ln_size;
    logic [1:0]             ln_off;
    logic                   ln_sgn;
    logic [XLEN-1:0]        ln_wdata;
    logic [STRB_W-1:0]      ln_wstrb;
    logic [XLEN-1:0]        ln_ld_val;

    assign ex_ready = (state_q == LSU_IDLE) && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = (ex_memop == MEMOP_LOAD) || (ex_memop == MEMOP_STORE);
    assign off_eff  = align_off(ex_size, ex_dest[1:0]);

    // The lane helper serves the incoming request in IDLE (store steering)
    // and the latched request in MEM (load extraction).
    assign ln_size = (state_q == LSU_IDLE) ? ex_size   : size_q;
    assign ln_off  = (state_q == LSU_IDLE) ? off_eff   : off_q;
    assign ln_sgn  = (state_q == LSU_IDLE) ? ex_signed : sgn_q;

    mr_lsu_lane u_lane (
        .size    (ln_size),
        .off     (ln_off),
        .sgn     (ln_sgn),
        .payload (ex_payload),
        .rdata   (mem_rdata),
        .wdata   (ln_wdata),
        .wstrb   (ln_wstrb),
        .ld_val  (ln_ld_val)
    );

`ifdef MR_LSU_MISALIGN_TRAP_EN
    logic            lsu_fault_q, lsu_fault_d;
    logic [XLEN-1:0] lsu_fault_addr_q, lsu_fault_addr_d;

    assign trap = misaligned(ex_size, ex_dest[1:0]);

    // One-cycle fault pulse on an accepted misaligned access; address is held.
    always_comb begin
        lsu_fault_d      = 1'b0;
        lsu_fault_addr_d = lsu_fault_addr_q;
        if (accept && is_mem && trap) begin
            lsu_fault_d      = 1'b1;
            lsu_fault_addr_d = ex_dest;
        end
    end

    // Fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_fault_q      <= 1'b0;
            lsu_fault_addr_q <= '0;
        end else begin
            lsu_fault_q      <= lsu_fault_d;
            lsu_fault_addr_q <= lsu_fault_addr_d;
        end
    end

    assign lsu_fault      = lsu_fault_q;
    assign lsu_fault_addr = lsu_fault_addr_q;
`else
    assign trap           = 1'b0;
    assign lsu_fault      = 1'b0;
    assign lsu_fault_addr = '0;
`endif

    // Next-state: accept in IDLE, hold the bus in MEM until ack, drain writeback.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = wb_valid_q;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        size_d      = size_q;
        off_d       = off_q;
        sgn_d       = sgn_q;
        dreg_d      = dreg_q;

        if (wb_valid_q && wb_ready)
            wb_valid_d = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (ex_memop == MEMOP_NONE) begin
                        wb_data_d  = ex_dest;
                        wb_reg_d   = ex_dest_reg;
                        wb_valid_d = (ex_dest_reg != '0);
                    end else if (is_mem && !trap) begin
                        size_d      = ex_size;
                        off_d       = off_eff;
                        sgn_d       = ex_signed;
                        dreg_d      = ex_dest_reg;
                        mem_addr_d  = {ex_dest[XLEN-1:2], 2'b00};
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ex_memop == MEMOP_STORE);
                        mem_wdata_d = (ex_memop == MEMOP_STORE) ? ln_wdata : '0;
                        mem_wstrb_d = (ex_memop == MEMOP_STORE) ? ln_wstrb : '0;
                        state_d     = LSU_MEM;
                    end
                end
            end
            LSU_MEM: begin
                if (mem_ack && mem_req_q) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = LSU_IDLE;
                    if (!mem_we_q) begin
                        wb_data_d  = ln_ld_val;
                        wb_reg_d   = dreg_q;
                        wb_valid_d = (dreg_q != '0);
                    end
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // FSM state and registered outputs; reset abandons any bus transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            size_q      <= MEMSZ_B;
            off_q       <= 2'b00;
            sgn_q       <= 1'b0;
            dreg_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sgn_q       <= sgn_d;
            dreg_q      <= dreg_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mr_lsu.sv
// Directed bench for mr_lsu: writeback results are scoreboarded through a queue,
// bus-side behaviour is checked inline.
module tb_mr_lsu;
    import mr_lsu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [XLEN-1:0]        ex_dest;
    logic [REGSEL_BITS-1:0] ex_dest_reg;
    e_memops                ex_memop;
    e_memsz                 ex_size;
    logic                   ex_signed;
    logic [XLEN-1:0]        ex_payload;
    logic                   mem_req;
    logic                   mem_we;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [STRB_W-1:0]      mem_wstrb;
    logic                   mem_ack;
    logic [XLEN-1:0]        mem_rdata;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [REGSEL_BITS-1:0] wb_reg;
    logic [XLEN-1:0]        wb_data;
    logic                   lsu_fault;
    logic [XLEN-1:0]        lsu_fault_addr;

    typedef struct packed {
        logic [REGSEL_BITS-1:0] r;
        logic [XLEN-1:0]        d;
    } wb_t;

    wb_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    mr_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_dest        (ex_dest),
        .ex_dest_reg    (ex_dest_reg),
        .ex_memop       (ex_memop),
        .ex_size        (ex_size),
        .ex_signed      (ex_signed),
        .ex_payload     (ex_payload),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .lsu_fault      (lsu_fault),
        .lsu_fault_addr (lsu_fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare a writeback handshake that completes at the coming edge.
    task automatic wb_mon();
        wb_t e;
        if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected: observed reg %0d data %h, expected no writeback", wb_reg, wb_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_reg", {27'b0, wb_reg}, {27'b0, e.r});
                chk("wb_data", wb_data, e.d);
            end
        end
    endtask

    task automatic cyc();
        #1;
        wb_mon();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input e_memops op, input e_memsz sz, input logic sg,
                      input logic [31:0] dest, input logic [4:0] rd, input logic [31:0] pl);
        ex_valid    = 1'b1;
        ex_memop    = op;
        ex_size     = sz;
        ex_signed   = sg;
        ex_dest     = dest;
        ex_dest_reg = rd;
        ex_payload  = pl;
    endtask

    task automatic do_store(input logic [31:0] dest, input e_memsz sz, input logic [31:0] pl,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_strb, input int waits, input string tag);
        ex(MEMOP_STORE, sz, 1'b0, dest, 5'd4, pl);
        cyc();
        ex_valid = 1'b0;
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd1);
        chk({tag, "_addr"}, mem_addr, e_addr);
        chk({tag, "_wdata"}, mem_wdata, e_wdata);
        chk({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, e_strb});
        chk({tag, "_exrdy_busy"}, {31'b0, ex_ready}, 32'd0);
        for (int w = 0; w < waits; w++) begin
            cyc();
            chk({tag, "_hold_req"}, {31'b0, mem_req}, 32'd1);
            chk({tag, "_hold_addr"}, mem_addr, e_addr);
            chk({tag, "_hold_exrdy"}, {31'b0, ex_ready}, 32'd0);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk({tag, "_req_drop"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_no_wb"}, {31'b0, wb_valid}, 32'd0);
        chk({tag, "_exrdy_back"}, {31'b0, ex_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] dest, input e_memsz sz, input logic sg,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] e_addr, input logic [31:0] e_val, input string tag);
        ex(MEMOP_LOAD, sz, sg, dest, rd, 32'h0);
        cyc();
        ex_valid = 1'b0;
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, e_addr);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        exp_q.push_back({rd, e_val});
        cyc();
        mem_ack = 1'b0;
        chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "_val"}, wb_data, e_val);
        chk({tag, "_req_drop"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_exrdy"}, {31'b0, ex_ready}, {31'b0, wb_ready});
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_dest = '0; ex_dest_reg = '0; ex_memop = MEMOP_NONE;
        ex_size = MEMSZ_W; ex_signed = 1'b0; ex_payload = '0;
        mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", {31'b0, lsu_fault}, 32'd0);
        chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);

        // Back-to-back pass-through results at full throughput.
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h11 * (i + 1), 5'(i + 1), 32'h0);
            exp_q.push_back({5'(i + 1), 32'(32'h11 * (i + 1))});
            #1;
            chk("bb_ex_ready", {31'b0, ex_ready}, 32'd1);
            cyc();
            chk("bb_wbv", {31'b0, wb_valid}, 32'd1);
            chk("bb_data", wb_data, 32'h11 * (i + 1));
        end
        // A result to x0 is discarded.
        ex(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h55, 5'd0, 32'h0);
        cyc();
        ex_valid = 1'b0;
        chk("x0_dropped", {31'b0, wb_valid}, 32'd0);

        // Stores: byte at top lane with wait states, half upper, full word.
        do_store(32'h1003, MEMSZ_B, 32'h000000A5, 32'h1000, 32'hA5A5A5A5, 4'b1000, 3, "stb");
        do_store(32'h1002, MEMSZ_H, 32'h1234BEEF, 32'h1000, 32'hBEEFBEEF, 4'b1100, 0, "sth");
        do_store(32'h1008, MEMSZ_W, 32'h01020304, 32'h1008, 32'h01020304, 4'b1111, 1, "stw");

        // Byte loads, signed and unsigned, earliest ack.
        do_load(32'h2001, MEMSZ_B, 1'b1, 32'h00008000, 5'd5, 32'h2000, 32'hFFFFFF80, "lbs");
        do_load(32'h2001, MEMSZ_B, 1'b0, 32'h00008000, 5'd6, 32'h2000, 32'h00000080, "lbu");
        cyc();

        // Signed half load held by writeback backpressure, then refill on release.
        wb_ready = 1'b0;
        do_load(32'h2002, MEMSZ_H, 1'b1, 32'h80011234, 5'd7, 32'h2000, 32'hFFFF8001, "lhs");
        ex(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h99, 5'd9, 32'h0);
        for (int w = 0; w < 4; w++) begin
            cyc();
            chk("bp_wbv", {31'b0, wb_valid}, 32'd1);
            chk("bp_data", wb_data, 32'hFFFF8001);
            chk("bp_exrdy", {31'b0, ex_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        exp_q.push_back({5'd9, 32'h99});
        #1;
        chk("refill_exrdy", {31'b0, ex_ready}, 32'd1);
        cyc();
        ex_valid = 1'b0;
        chk("refill_wbv", {31'b0, wb_valid}, 32'd1);
        chk("refill_data", wb_data, 32'h99);
        cyc();

`ifdef MR_LSU_MISALIGN_TRAP_EN
        // Misaligned word traps without a bus cycle or writeback.
        ex(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h3002, 5'd8, 32'h0);
        cyc();
        ex_valid = 1'b0;
        chk("trap_fault", {31'b0, lsu_fault}, 32'd1);
        chk("trap_addr", lsu_fault_addr, 32'h3002);
        chk("trap_no_req", {31'b0, mem_req}, 32'd0);
        chk("trap_exrdy", {31'b0, ex_ready}, 32'd1);
        cyc();
        chk("trap_pulse_end", {31'b0, lsu_fault}, 32'd0);
        chk("trap_no_req2", {31'b0, mem_req}, 32'd0);
        chk("trap_no_wb", {31'b0, wb_valid}, 32'd0);
`else
        // Misaligned accesses are forced aligned.
        do_load(32'h3002, MEMSZ_W, 1'b0, 32'hDEADBEEF, 5'd8, 32'h3000, 32'hDEADBEEF, "lw_mis");
        chk("lw_mis_nofault", {31'b0, lsu_fault}, 32'd0);
        do_load(32'h2003, MEMSZ_H, 1'b0, 32'h80011234, 5'd12, 32'h2000, 32'h00008001, "lh_mis");
        cyc();
`endif

        // Reset while waiting for an ack abandons the transfer.
        ex(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h4000, 5'd11, 32'h0);
        cyc();
        ex_valid = 1'b0;
        chk("rmem_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rmem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("rmem_wbv", {31'b0, wb_valid}, 32'd0);
        chk("rmem_exrdy", {31'b0, ex_ready}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        cyc();
        mem_ack = 1'b0;
        chk("late_ack_wbv", {31'b0, wb_valid}, 32'd0);
        chk("late_ack_req", {31'b0, mem_req}, 32'd0);
        ex(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h1234, 5'd10, 32'h0);
        exp_q.push_back({5'd10, 32'h1234});
        cyc();
        ex_valid = 1'b0;
        chk("post_rst_wbv", {31'b0, wb_valid}, 32'd1);
        chk("post_rst_data", wb_data, 32'h1234);
        cyc();
        cyc();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
